// File: rtl/debug_sequencer_if.sv
// Debug sequencer bus bundle: RX/TX UART FIFO handshakes plus pipeline debug and load signals.
// The master modport is the sequencer side; the slave modport is the FIFO/pipeline side.
interface debug_sequencer_if #(
    parameter int N       = 8,
    parameter int W       = 5,
    parameter int PC_SZ   = 32,
    parameter int INST_SZ = 32,
    parameter int DATA_SZ = 32
);
    logic               i_rx_empty;
    logic [N-1:0]       i_rx_data;
    logic               o_rx_rd;
    logic               i_tx_full;
    logic               o_tx_wr;
    logic [N-1:0]       o_tx_data;
    logic [PC_SZ-1:0]   i_pc;
    logic [DATA_SZ-1:0] i_register_data;
    logic [DATA_SZ-1:0] i_memory_data;
    logic               i_halt;
    logic [INST_SZ-1:0] o_instruction;
    logic               o_mem_w;
    logic               o_enable;
    logic [W-1:0]       o_addr;

    modport master (
        input  i_rx_empty, i_rx_data, i_tx_full, i_pc, i_register_data, i_memory_data, i_halt,
        output o_rx_rd, o_tx_wr, o_tx_data, o_instruction, o_mem_w, o_enable, o_addr
    );

    modport slave (
        output i_rx_empty, i_rx_data, i_tx_full, i_pc, i_register_data, i_memory_data, i_halt,
        input  o_rx_rd, o_tx_wr, o_tx_data, o_instruction, o_mem_w, o_enable, o_addr
    );
endinterface

// File: rtl/debug_sequencer.sv
// UART-driven debug sequencer: loads instruction words, runs or single-steps the pipeline,
// then streams PC, register file and data memory out MSB first, stalling while TX is full.
module debug_sequencer #(
    parameter int                 N       = 8,
    parameter int                 W       = 5,
    parameter int                 PC_SZ   = 32,
    parameter int                 INST_SZ = 32,
    parameter int                 DATA_SZ = 32,
    parameter logic [INST_SZ-1:0] HALT_OP = 32'hFFFF_FFFF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    debug_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_WR,
        S_RUN,
        S_STEP,
        S_DUMP_SET,
        S_DUMP_SEND
    } state_t;

    localparam logic [N-1:0]   CMD_LOAD    = N'(8'h4C);
    localparam logic [N-1:0]   CMD_RUN     = N'(8'h43);
    localparam logic [N-1:0]   CMD_STEP    = N'(8'h53);
    localparam int             NREG        = 1 << W;
    localparam logic [W+1:0]   WC_ONE      = (W+2)'(1);
    localparam logic [W+1:0]   WC_REG_LAST = (W+2)'(NREG);
    localparam logic [W+1:0]   WC_LAST     = (W+2)'(2 * NREG);
    localparam logic [W-1:0]   ADDR_ONE    = W'(1);

    state_t             state_q, state_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [W+1:0]       word_cnt_q, word_cnt_d;
    logic [W-1:0]       addr_q, addr_d;
    logic [INST_SZ-1:0] instr_q, instr_d;
    logic [DATA_SZ-1:0] shift_q, shift_d;
    logic               rx_rd;
    logic               tx_wr;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            instr_q    <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        shift_d    = shift_q;
        rx_rd      = 1'b0;
        tx_wr      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.i_rx_empty) begin
                    rx_rd = 1'b1;
                    case (bus.i_rx_data)
                        CMD_LOAD: state_d = S_LOAD;
                        CMD_RUN:  state_d = S_RUN;
                        CMD_STEP: state_d = S_STEP;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end

            S_LOAD: begin
                if (!bus.i_rx_empty) begin
                    rx_rd      = 1'b1;
                    instr_d    = {instr_q[INST_SZ-N-1:0], bus.i_rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_LOAD_WR;
                    end
                end
            end

            // The halt word is itself written before loading stops.
            S_LOAD_WR: begin
                state_d = (instr_q == HALT_OP) ? S_IDLE : S_LOAD;
            end

            S_RUN: begin
                if (bus.i_halt) begin
                    state_d = S_DUMP_SET;
                end
            end

            S_STEP: begin
                state_d = S_DUMP_SET;
            end

            // Word 0 is the PC, then NREG register words, then NREG memory words.
            S_DUMP_SET: begin
                if (word_cnt_q == '0) begin
                    shift_d = DATA_SZ'(bus.i_pc);
                end else if (word_cnt_q <= WC_REG_LAST) begin
                    shift_d = bus.i_register_data;
                end else begin
                    shift_d = bus.i_memory_data;
                end
                state_d = S_DUMP_SEND;
            end

            S_DUMP_SEND: begin
                if (!bus.i_tx_full) begin
                    tx_wr      = 1'b1;
                    shift_d    = shift_q << N;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (word_cnt_q == WC_LAST) begin
                            word_cnt_d = '0;
                            addr_d     = '0;
                            state_d    = S_IDLE;
                        end else begin
                            word_cnt_d = word_cnt_q + WC_ONE;
                            if (word_cnt_q != '0) begin
                                addr_d = addr_q + ADDR_ONE;
                            end
                            state_d = S_DUMP_SET;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The pop strobe is combinational on the FIFO head, so it is gated while reset is held.
    assign bus.o_rx_rd       = rx_rd & ~i_reset;
    assign bus.o_tx_wr       = tx_wr;
    assign bus.o_tx_data     = shift_q[DATA_SZ-1 -: N];
    assign bus.o_instruction = instr_q;
    assign bus.o_mem_w       = (state_q == S_LOAD_WR);
    assign bus.o_enable      = (state_q == S_RUN) || (state_q == S_STEP);
    assign bus.o_addr        = addr_q;
endmodule

// File: tb/tb_debug_sequencer.sv
// Bench for debug_sequencer: FIFO/pipeline models around the DUT, randomized data checked
// against a dump-stream and load-word reference built from the command rules.
module tb_debug_sequencer;
    localparam int NW         = 32;
    localparam int DUMP_BYTES = 4 * (1 + 2 * NW);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    debug_sequencer_if bus ();
    debug_sequencer dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_got[$];
    logic [31:0] wr_got[$];
    logic [7:0]  exp_q[$];
    logic [31:0] reg_arr[NW];
    logic [31:0] mem_arr[NW];
    logic [31:0] pc_val = 32'h0;
    logic        tx_full = 1'b0;
    logic        halt = 1'b0;
    logic        pop_pend;
    int          en_cnt = 0;
    int          viol_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    always_comb begin
        bus.i_pc            = pc_val;
        bus.i_register_data = reg_arr[bus.o_addr];
        bus.i_memory_data   = mem_arr[bus.o_addr];
        bus.i_tx_full       = tx_full;
        bus.i_halt          = halt;
    end

    // First-word-fall-through RX FIFO: head presented at negedge, popped at the strobed posedge.
    always @(negedge clk) begin
        bus.i_rx_empty = (rx_q.size() == 0);
        bus.i_rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        #1;
        pop_pend = bus.o_rx_rd && !rst;
    end
    always @(posedge clk) if (pop_pend) void'(rx_q.pop_front());

    always @(negedge clk) begin
        if (bus.o_enable) en_cnt++;
        if (bus.o_mem_w) wr_got.push_back(bus.o_instruction);
        if (bus.o_tx_wr) begin
            tx_got.push_back(bus.o_tx_data);
            if (tx_full) viol_cnt++;
        end
    end

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) rx_q.push_back(w[8*b +: 8]);
    endtask

    task automatic build_expected();
        exp_q.delete();
        for (int b = 3; b >= 0; b--) exp_q.push_back(pc_val[8*b +: 8]);
        for (int n = 0; n < NW; n++)
            for (int b = 3; b >= 0; b--) exp_q.push_back(reg_arr[n][8*b +: 8]);
        for (int n = 0; n < NW; n++)
            for (int b = 3; b >= 0; b--) exp_q.push_back(mem_arr[n][8*b +: 8]);
    endtask

    task automatic randomize_state();
        pc_val = $urandom;
        for (int n = 0; n < NW; n++) begin
            reg_arr[n] = $urandom;
            mem_arr[n] = $urandom;
        end
        build_expected();
    endtask

    // Index of the first byte differing from reps copies of exp_q starting at base, or -1.
    function automatic int first_diff(input int base, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < DUMP_BYTES; i++) begin
                if (base + r * DUMP_BYTES + i >= tx_got.size()) return r * DUMP_BYTES + i;
                if (tx_got[base + r * DUMP_BYTES + i] !== exp_q[i]) return r * DUMP_BYTES + i;
            end
        return -1;
    endfunction

    function automatic logic [31:0] tx_word(input int idx);
        if (idx + 3 >= tx_got.size()) return 32'hxxxx_xxxx;
        return {tx_got[idx], tx_got[idx+1], tx_got[idx+2], tx_got[idx+3]};
    endfunction

    task automatic wait_tx(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (tx_got.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (rx_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_q.push_back(8'h31);
        repeat (3) @(negedge clk);
        #2;
        checks++; if (bus.o_rx_rd !== 1'b0) begin errors++; $display("FAIL reset_rx_rd got %b want 0", bus.o_rx_rd); end
        checks++; if (bus.o_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %b want 0", bus.o_enable); end
        checks++; if (bus.o_mem_w !== 1'b0) begin errors++; $display("FAIL reset_mem_w got %b want 0", bus.o_mem_w); end
        checks++; if (bus.o_tx_wr !== 1'b0) begin errors++; $display("FAIL reset_tx_wr got %b want 0", bus.o_tx_wr); end
        checks++; if (bus.o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", bus.o_tx_data); end
        checks++; if (bus.o_instruction !== 32'h0) begin errors++; $display("FAIL reset_instruction got %h want 0", bus.o_instruction); end
        checks++; if (bus.o_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", bus.o_addr); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL reset_garbage_pop got %0d bytes left want 0", rx_q.size()); end
        checks++; if (wr_got.size() + tx_got.size() + en_cnt != 0) begin
            errors++; $display("FAIL reset_garbage_effect got wr=%0d tx=%0d en=%0d want 0", wr_got.size(), tx_got.size(), en_cnt);
        end
    endtask

    task automatic test_load();
        int wr0, tx0, en0, k;
        bit ok;
        logic [31:0] words[$];
        wr0 = wr_got.size(); tx0 = tx_got.size(); en0 = en_cnt;
        rx_q.push_back(8'h4C);
        push_word(32'h0000_0013);
        push_word(32'hFFFF_FFFF);
        wait_drain(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL load_drain timeout, %0d bytes left want 0", rx_q.size()); end
        checks++; if (wr_got.size() - wr0 != 2) begin errors++; $display("FAIL load_count got %0d want 2", wr_got.size() - wr0); end
        checks++; if (wr_got.size() >= wr0 + 2 && (wr_got[wr0] !== 32'h13 || wr_got[wr0+1] !== 32'hFFFF_FFFF)) begin
            errors++; $display("FAIL load_words got %h %h want 00000013 ffffffff", wr_got[wr0], wr_got[wr0+1]);
        end
        wr0 = wr_got.size();
        k = $urandom_range(2, 6);
        rx_q.push_back(8'h4C);
        for (int i = 0; i < k; i++) begin
            words.push_back($urandom);
            if (words[i] == 32'hFFFF_FFFF) words[i] = 32'h0;
            push_word(words[i]);
        end
        words.push_back(32'hFFFF_FFFF);
        push_word(32'hFFFF_FFFF);
        wait_drain(400, ok);
        checks++; if (wr_got.size() - wr0 != k + 1) begin errors++; $display("FAIL load_rand_count got %0d want %0d", wr_got.size() - wr0, k + 1); end
        for (int i = 0; i <= k; i++) begin
            checks++;
            if (wr0 + i >= wr_got.size() || wr_got[wr0+i] !== words[i]) begin
                errors++; $display("FAIL load_rand_word[%0d] got %h want %h", i, (wr0 + i < wr_got.size()) ? wr_got[wr0+i] : 32'hx, words[i]);
            end
        end
        checks++; if (tx_got.size() != tx0 || en_cnt != en0) begin
            errors++; $display("FAIL load_side_effect got tx=%0d en=%0d want tx=%0d en=%0d", tx_got.size(), en_cnt, tx0, en0);
        end
    endtask

    task automatic test_run(input int k);
        int tx0, en0, wr0, df;
        bit ok, ok2;
        randomize_state();
        tx0 = tx_got.size(); en0 = en_cnt; wr0 = wr_got.size();
        halt = 1'b0;
        rx_q.push_back(8'h43);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (en_cnt - en0 >= k) begin
                halt = 1'b1;
                ok = 1'b1;
                break;
            end
        end
        wait_tx(tx0 + DUMP_BYTES, 3000, ok2);
        repeat (10) @(posedge clk);
        #1 halt = 1'b0;
        checks++; if (!ok || !ok2) begin errors++; $display("FAIL run_timeout got enable_seen=%b dump_done=%b want 1 1", ok, ok2); end
        checks++; if (en_cnt - en0 != k) begin errors++; $display("FAIL run_enable_cycles got %0d want %0d", en_cnt - en0, k); end
        checks++; if (tx_got.size() - tx0 != DUMP_BYTES) begin errors++; $display("FAIL run_tx_count got %0d want %0d", tx_got.size() - tx0, DUMP_BYTES); end
        checks++; if (tx_word(tx0) !== pc_val) begin errors++; $display("FAIL run_pc_bytes got %h want %h", tx_word(tx0), pc_val); end
        df = first_diff(tx0, 1);
        checks++; if (df != -1) begin errors++; $display("FAIL run_stream byte %0d got %h want %h", df, tx_got[tx0+df], exp_q[df % DUMP_BYTES]); end
        checks++; if (wr_got.size() != wr0) begin errors++; $display("FAIL run_mem_w got %0d writes want 0", wr_got.size() - wr0); end
    endtask

    task automatic test_step(input logic halt_level);
        int tx0, en0, df;
        bit ok;
        pc_val = $urandom;
        for (int n = 0; n < NW; n++) begin
            reg_arr[n] = n;
            mem_arr[n] = 32'h100 + n;
        end
        build_expected();
        tx0 = tx_got.size(); en0 = en_cnt;
        halt = halt_level;
        rx_q.push_back(8'h53);
        wait_tx(tx0 + DUMP_BYTES, 3000, ok);
        repeat (10) @(posedge clk);
        #1 halt = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL step_timeout got %0d bytes want %0d", tx_got.size() - tx0, DUMP_BYTES); end
        checks++; if (en_cnt - en0 != 1) begin errors++; $display("FAIL step_enable_pulses(halt=%b) got %0d want 1", halt_level, en_cnt - en0); end
        checks++; if (tx_word(tx0 + 4) !== 32'h0) begin errors++; $display("FAIL step_reg0 got %h want 00000000", tx_word(tx0 + 4)); end
        checks++; if (tx_word(tx0 + 128) !== 32'h1F) begin errors++; $display("FAIL step_reg31 got %h want 0000001f", tx_word(tx0 + 128)); end
        checks++; if (tx_word(tx0 + 132) !== 32'h100) begin errors++; $display("FAIL step_mem0 got %h want 00000100", tx_word(tx0 + 132)); end
        checks++; if (tx_got.size() - tx0 != DUMP_BYTES) begin errors++; $display("FAIL step_tx_count got %0d want %0d", tx_got.size() - tx0, DUMP_BYTES); end
        df = first_diff(tx0, 1);
        checks++; if (df != -1) begin errors++; $display("FAIL step_stream byte %0d got %h want %h", df, tx_got[tx0+df], exp_q[df % DUMP_BYTES]); end
    endtask

    task automatic test_backpressure();
        int tx0, n_stall, v0, df;
        bit ok;
        randomize_state();
        tx0 = tx_got.size(); v0 = viol_cnt;
        rx_q.push_back(8'h53);
        wait_tx(tx0 + 50, 1000, ok);
        tx_full = 1'b1;
        n_stall = tx_got.size();
        repeat (20) @(posedge clk);
        #1;
        checks++; if (tx_got.size() != n_stall) begin errors++; $display("FAIL bp_stall_bytes got %0d want 0", tx_got.size() - n_stall); end
        tx_full = 1'b0;
        wait_tx(tx0 + DUMP_BYTES, 3000, ok);
        checks++; if (viol_cnt != v0) begin errors++; $display("FAIL bp_wr_while_full got %0d want 0", viol_cnt - v0); end
        df = first_diff(tx0, 1);
        checks++; if (df != -1 || tx_got.size() - tx0 != DUMP_BYTES) begin
            errors++; $display("FAIL bp_stream first_diff %0d count %0d want -1 and %0d", df, tx_got.size() - tx0, DUMP_BYTES);
        end
        // Random full/not-full jitter over a whole dump.
        randomize_state();
        tx0 = tx_got.size(); v0 = viol_cnt;
        rx_q.push_back(8'h53);
        ok = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            tx_full = 1'($urandom_range(0, 1));
            if (tx_got.size() >= tx0 + DUMP_BYTES) begin
                ok = 1'b1;
                break;
            end
        end
        tx_full = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (!ok || viol_cnt != v0) begin errors++; $display("FAIL bp_jitter done=%b violations %0d want 1 and 0", ok, viol_cnt - v0); end
        df = first_diff(tx0, 1);
        checks++; if (df != -1 || tx_got.size() - tx0 != DUMP_BYTES) begin
            errors++; $display("FAIL bp_jitter_stream first_diff %0d count %0d want -1 and %0d", df, tx_got.size() - tx0, DUMP_BYTES);
        end
    endtask

    task automatic test_back_to_back();
        int tx0, en0, df;
        bit ok;
        randomize_state();
        tx0 = tx_got.size(); en0 = en_cnt;
        rx_q.push_back(8'h7A);
        rx_q.push_back(8'h53);
        rx_q.push_back(8'h53);
        wait_tx(tx0 + 100, 1000, ok);
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL b2b_pending_rx got %0d want 1", rx_q.size()); end
        wait_tx(tx0 + 2 * DUMP_BYTES, 3000, ok);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (en_cnt - en0 != 2) begin errors++; $display("FAIL b2b_enable_pulses got %0d want 2", en_cnt - en0); end
        df = first_diff(tx0, 2);
        checks++; if (df != -1 || tx_got.size() - tx0 != 2 * DUMP_BYTES) begin
            errors++; $display("FAIL b2b_stream first_diff %0d count %0d want -1 and %0d", df, tx_got.size() - tx0, 2 * DUMP_BYTES);
        end
    endtask

    task automatic test_reset_mid_load();
        int wr0;
        bit ok;
        wr0 = wr_got.size();
        rx_q.push_back(8'h4C);
        rx_q.push_back(8'hAA);
        rx_q.push_back(8'hBB);
        wait_drain(100, ok);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (wr_got.size() != wr0) begin errors++; $display("FAIL rst_load_partial got %0d writes want 0", wr_got.size() - wr0); end
        rx_q.push_back(8'h4C);
        push_word(32'h0000_002A);
        push_word(32'hFFFF_FFFF);
        wait_drain(200, ok);
        checks++; if (wr_got.size() - wr0 != 2 || wr_got[wr0] !== 32'h2A || wr_got[wr0+1] !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL rst_load_fresh got %0d writes first %h want 2 writes 0000002a ffffffff",
                               wr_got.size() - wr0, (wr_got.size() > wr0) ? wr_got[wr0] : 32'hx);
        end
    endtask

    task automatic test_reset_mid_dump();
        int tx0, n_after;
        bit ok;
        randomize_state();
        tx0 = tx_got.size();
        rx_q.push_back(8'h53);
        wait_tx(tx0 + 40, 1000, ok);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.o_tx_wr !== 1'b0 || bus.o_addr !== 5'd0 || bus.o_tx_data !== 8'h00) begin
            errors++; $display("FAIL rst_dump_async got wr=%b addr=%0d data=%h want 0 0 00", bus.o_tx_wr, bus.o_addr, bus.o_tx_data);
        end
        @(posedge clk); #1 rst = 1'b0;
        n_after = tx_got.size();
        repeat (30) @(posedge clk);
        #1;
        checks++; if (tx_got.size() != n_after) begin errors++; $display("FAIL rst_dump_more_tx got %0d bytes want 0", tx_got.size() - n_after); end
    endtask

    initial begin
        for (int n = 0; n < NW; n++) begin
            reg_arr[n] = 32'h0;
            mem_arr[n] = 32'h0;
        end
        test_reset();
        test_load();
        test_run(10);
        test_run($urandom_range(1, 30));
        test_step(1'b0);
        test_step(1'b1);
        test_backpressure();
        test_back_to_back();
        test_reset_mid_load();
        test_reset_mid_dump();
        test_step(1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/debug_sequencer.md
DEBUG_SEQUENCER -- requirements
Module: debug_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- N, 8, UART byte width.
- W, 5, debug address bits for register file and data memory.
- PC_SZ, 32, program counter width.
- INST_SZ, 32, instruction width.
- DATA_SZ, 32, debug data width.
- HALT_OP, 32'hFFFF_FFFF, instruction word that ends a load.

REQ-002 Ports (name, direction, width, meaning):
- i_clk, in, 1, single clock.
- i_reset, in, 1, reset; asynchronous, active-high.
- i_rx_empty, in, 1, RX FIFO empty.
- i_rx_data, in, N, RX FIFO head byte; first-word-fall-through, valid when i_rx_empty=0.
- o_rx_rd, out, 1, RX pop strobe.
- i_tx_full, in, 1, TX FIFO full.
- o_tx_wr, out, 1, TX push strobe.
- o_tx_data, out, N, TX byte.
- i_pc, in, PC_SZ, current pipeline PC.
- i_register_data, in, DATA_SZ, register at o_addr.
- i_memory_data, in, DATA_SZ, memory word at o_addr.
- i_halt, in, 1, pipeline executed halt.
- o_instruction, out, INST_SZ, assembled instruction.
- o_mem_w, out, 1, instruction write strobe.
- o_enable, out, 1, pipeline execute enable.
- o_addr, out, W, debug read address.

Function
REQ-003 States: IDLE, LOAD, LOAD_WR, RUN, STEP, DUMP_SET, DUMP_SEND.
REQ-004 Command bytes accepted only in IDLE:
- 0x4C 'L' -> LOAD.
- 0x43 'C' -> RUN.
- 0x53 'S' -> STEP.
- Any other byte is popped and discarded; state stays IDLE.
REQ-005 RX pop: o_rx_rd is a one-cycle pulse, asserted only when i_rx_empty=0, and only in IDLE or LOAD; i_rx_data is sampled in the same cycle.
REQ-006 LOAD assembly:
- Four bytes form one word, MSB first.
- A 2-bit byte counter wraps 3->0; the fourth byte moves to LOAD_WR.
REQ-007 LOAD_WR: o_instruction = assembled word and o_mem_w=1 for exactly one cycle, then:
- word == HALT_OP -> IDLE (the HALT_OP word itself is written);
- otherwise -> LOAD.
REQ-008 RUN:
- o_enable=1 every cycle until i_halt=1 is sampled.
- That cycle: o_enable=0 in the following cycle, go to DUMP_SET.
REQ-009 STEP:
- o_enable=1 for exactly one cycle, then DUMP_SET.
- If i_halt is already 1, o_enable is still pulsed; the pipeline ignores it.
REQ-010 Dump sequence, 1 + 2*2^W words, each sent as 4 bytes MSB first:
- i_pc;
- i_register_data for o_addr = 0 .. 2^W-1;
- i_memory_data for o_addr = 0 .. 2^W-1.
REQ-011 DUMP_SET:
- Drive o_addr for one cycle (read latency 1).
- Capture the selected 32-bit word into a shift register.
- Then DUMP_SEND.
REQ-012 DUMP_SEND:
- Each cycle with i_tx_full=0: o_tx_wr=1, o_tx_data = shift register MSB byte, shift left 8.
- With i_tx_full=1: o_tx_wr=0 and all counters hold.
REQ-013 After the 4th byte of a word:
- More words remain -> DUMP_SET; the address counter increments and wraps 2^W-1 -> 0 between the register and memory phases.
- Last memory word -> IDLE.
REQ-014 o_enable=0 and o_mem_w=0 in IDLE, LOAD, DUMP_SET and DUMP_SEND.
REQ-015 RX bytes arriving during RUN, STEP or dump remain in the FIFO (no pop) and are processed on return to IDLE.
REQ-016 Arithmetic:
- Word counter is W+2 bits.
- Byte counter is 2 bits.
- No overflow is possible beyond the stated wraps.

Reset
REQ-017 i_reset=1 forces asynchronously:
- state=IDLE;
- all counters and the shift register 0;
- o_rx_rd, o_tx_wr, o_mem_w, o_enable = 0;
- o_tx_data, o_instruction, o_addr = 0.
REQ-018 Reset mid-load or mid-dump abandons the operation: no partial word write, no further TX bytes.

Verification
REQ-019 Load: RX 4C, 00 00 00 13, FF FF FF FF -> exactly two o_mem_w pulses, instructions 0x00000013 then 0xFFFFFFFF; return to IDLE.
REQ-020 Run: RX 43, i_halt raised 10 cycles later -> o_enable high for exactly 10 cycles; then 260 TX bytes (W=5); first 4 bytes = i_pc MSB first.
REQ-021 Step: RX 53 with register[n] = n and memory[n] = 0x100+n ->
- one o_enable pulse;
- bytes 4..7 = 00 00 00 00; bytes 128..131 = 00 00 00 1F; bytes 132..135 = 00 00 01 00.
REQ-022 Backpressure: hold i_tx_full=1 for 20 cycles mid-dump -> no o_tx_wr during the stall; byte stream identical to the unstalled case.
REQ-023 Garbage: RX 0x7A then 53 -> 0x7A dropped, step and dump executed normally.
REQ-024 Reset mid-load after 2 of 4 bytes: pulse i_reset -> no o_mem_w; next RX 4C starts a fresh word at byte 0.
